vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port VDC VRAM (32K x 16) between three requesters:
//  - BG/sprite render fetch (bg)
//  - CPU VWR/VRR port (cpu)
//  - VRAM-VRAM / SATB DMA engine (dma)
//  Sits between those engines and the VRAM model. Grants one access per cycle,
//  drives the VRAM command registers and routes read data back with a tag.
//  Prevents CPU starvation during active display.
// PARAMETERS
//  CPU_MAX_WAIT  8   cycles cpu_req may wait unacked before it outranks bg
//  WAIT_W        4   width of the CPU wait counter; must hold CPU_MAX_WAIT
// PORTS
//  clock        in   1   system clock; single clock domain
//  reset_N      in   1   asynchronous, active-low reset
//  bg_req       in   1   render read request; bg_addr stable while high
//  bg_addr      in   16  render word address
//  bg_ack       out  1   bg request accepted this cycle
//  bg_rvalid    out  1   rdata belongs to bg this cycle
//  cpu_req      in   1   CPU request; cpu_we/addr/wdata stable while high
//  cpu_we       in   1   1 = write, 0 = read
//  cpu_addr     in   16  CPU word address
//  cpu_wdata    in   16  CPU write data
//  cpu_ack      out  1   cpu request accepted this cycle
//  cpu_rvalid   out  1   rdata belongs to cpu this cycle
//  dma_req      in   1   DMA request; dma_we/addr/wdata stable while high
//  dma_we       in   1   1 = write, 0 = read
//  dma_addr     in   16  DMA word address
//  dma_wdata    in   16  DMA write data
//  dma_ack      out  1   dma request accepted this cycle
//  dma_rvalid   out  1   rdata belongs to dma this cycle
//  rdata        out  16  shared read-return data, qualified by *_rvalid
//  vram_addr    out  16  to VRAM MA (registered)
//  vram_re      out  1   to VRAM re (registered)
//  vram_we      out  1   to VRAM we (registered)
//  vram_wdata   out  16  to VRAM MD_in (registered)
//  vram_rdata   in   16  from VRAM MD_out (valid the cycle after vram_re)
// BEHAVIOUR
//  - Reset values: all *_ack, *_rvalid, vram_re and vram_we = 0.
//    vram_addr, vram_wdata and rdata = 0. Wait counter = 0. rr pointer = CPU.
//  - Handshake:
//    - *_ack is combinational in cycle N from the current req.
//    - A request is accepted on the clock edge where req && ack.
//    - The requester may present a new request in cycle N+1 (back-to-back).
//    - The requester must not change its fields while req && !ack.
//  - Priority in cycle N, at most one ack:
//    1. cpu, if cpu_req and wait_cnt >= CPU_MAX_WAIT
//    2. bg
//    3. round-robin between cpu and dma (rr pointer).
//    The rr pointer flips to the other requester after each cpu or dma grant.
//  - wait_cnt:
//    - +1 each cycle cpu_req && !cpu_ack, saturating at 2^WAIT_W-1.
//    - Cleared on cpu_ack, and whenever cpu_req = 0.
//  - Command (N+1): registers vram_addr, vram_wdata, and vram_re = !we or vram_we = we.
//    vram_re and vram_we are never both 1. Idle cycles: re = we = 0; addr and wdata hold.
//  - Read return: a 2-stage tag pipeline follows each accepted read.
//    The matching *_rvalid = 1 in cycle N+2. rdata = vram_rdata in that cycle.
//    Fixed ack-to-rvalid latency = 2. One rvalid per read, in grant order.
//  - Out-of-range address (addr[15] = 1), acked normally:
//    - Write: no vram_we is issued (dropped).
//    - Read: no vram_re is issued. rvalid is still asserted at N+2 with rdata = 16'h0000.
//  - Writes produce no rvalid. Write-then-read of the same address on consecutive
//    grants returns the new data.
//  - Reset mid-operation clears the tag pipeline, so in-flight reads never return.
//    Requesters must re-issue after reset.
// STRUCTURE
//  - vdc_pkg:
//    - typedef enum logic [1:0] {REQ_NONE, REQ_BG, REQ_CPU, REQ_DMA} vram_req_t
//    - localparam VRAM_WORDS = 32768
//    - localparam VRAM_RD_LAT = 2
//  - Sub-module vram_grant_pick: purely combinational priority + round-robin picker.
//    Outputs a vram_req_t. The wait counter, rr flop, command regs and tag pipe stay in the top.
// TESTING
//  1. After reset: all outputs 0. bg_req=1, bg_addr=16'h0100 at N
//     -> bg_ack@N, vram_re=1/vram_addr=16'h0100@N+1, bg_rvalid@N+2 with rdata = VRAM[0x100].
//  2. cpu write 16'h1234 to 16'h0040, then cpu read 16'h0040 back-to-back
//     -> vram_we@N+1, vram_re@N+2, cpu_rvalid@N+3 with rdata = 16'h1234.
//  3. cpu_req and dma_req both held high for 4 cycles, bg idle
//     -> acks alternate cpu, dma, cpu, dma.
//  4. bg_req and cpu_req both held high, CPU_MAX_WAIT=8
//     -> bg acked 8 cycles, cpu_ack on cycle 9, bg resumes cycle 10, wait_cnt=0.
//  5. dma write 16'hBEEF to 16'h8005
//     -> dma_ack, no vram_we. dma read 16'h8005 -> dma_rvalid@+2 with rdata = 16'h0000, no vram_re.
//  6. reset_N low one cycle after cpu read ack
//     -> cpu_rvalid never asserts. All outputs return to reset values immediately.

Source files
------------

// File: rtl/vdc_pkg.sv
// Shared types and constants for the VDC VRAM access path.
// The arbiter and its grant picker both use these definitions.
package vdc_pkg;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_BG   = 2'd1,
        REQ_CPU  = 2'd2,
        REQ_DMA  = 2'd3
    } vram_req_t;

    localparam int VRAM_WORDS  = 32768;
    localparam int VRAM_RD_LAT = 2;

    typedef struct packed {
        logic      valid;
        logic      oor;
        vram_req_t owner;
    } rd_tag_t;

    // Word addresses at or above the physical array size are never sent to VRAM.
    function automatic logic addr_in_range(input logic [15:0] addr);
        return ({1'b0, addr} < 17'(VRAM_WORDS));
    endfunction

endpackage

// File: rtl/vram_grant_pick.sv
// Combinational grant selection for the VRAM arbiter.
// Order: starving CPU, then render fetch, then CPU/DMA round-robin.
module vram_grant_pick
    import vdc_pkg::*;
(
    input  logic      bg_req,
    input  logic      cpu_req,
    input  logic      dma_req,
    input  logic      cpu_urgent,
    input  logic      rr_cpu,
    output vram_req_t grant
);

    // Priority chain with round-robin tie-break between CPU and DMA
    always_comb begin
        grant = REQ_NONE;
        if (cpu_urgent) begin
            grant = REQ_CPU;
        end else if (bg_req) begin
            grant = REQ_BG;
        end else if (cpu_req && dma_req) begin
            grant = rr_cpu ? REQ_CPU : REQ_DMA;
        end else if (cpu_req) begin
            grant = REQ_CPU;
        end else if (dma_req) begin
            grant = REQ_DMA;
        end else begin
            grant = REQ_NONE;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter for render fetch, CPU and DMA requesters.
// Issues one registered VRAM command per cycle and returns read data with owner tags.
module vram_arbiter
    import vdc_pkg::*;
#(
    parameter int CPU_MAX_WAIT = 8,
    parameter int WAIT_W       = 4
) (
    input  logic        clock,
    input  logic        reset_N,
    input  logic        bg_req,
    input  logic [15:0] bg_addr,
    output logic        bg_ack,
    output logic        bg_rvalid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rvalid,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic        dma_rvalid,
    output logic [15:0] rdata,
    output logic [15:0] vram_addr,
    output logic        vram_re,
    output logic        vram_we,
    output logic [15:0] vram_wdata,
    input  logic [15:0] vram_rdata
);

    vram_req_t         grant_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              rr_cpu_r;
    logic              cpu_urgent_s;
    logic              sel_valid_s;
    logic              sel_we_s;
    logic [15:0]       sel_addr_s;
    logic [15:0]       sel_wdata_s;
    logic              sel_in_range_s;
    rd_tag_t           new_tag_s;
    rd_tag_t           ret_tag_s;
    rd_tag_t           tag_pipe_r [VRAM_RD_LAT];

    assign cpu_urgent_s = cpu_req && (wait_cnt_r >= WAIT_W'(CPU_MAX_WAIT));

    vram_grant_pick u_pick (
        .bg_req     (bg_req),
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .cpu_urgent (cpu_urgent_s),
        .rr_cpu     (rr_cpu_r),
        .grant      (grant_s)
    );

    assign bg_ack  = (grant_s == REQ_BG);
    assign cpu_ack = (grant_s == REQ_CPU);
    assign dma_ack = (grant_s == REQ_DMA);

    // Route the granted requester's command fields
    always_comb begin
        sel_valid_s = 1'b0;
        sel_we_s    = 1'b0;
        sel_addr_s  = 16'h0000;
        sel_wdata_s = 16'h0000;
        case (grant_s)
            REQ_BG: begin
                sel_valid_s = 1'b1;
                sel_we_s    = 1'b0;
                sel_addr_s  = bg_addr;
                sel_wdata_s = 16'h0000;
            end
            REQ_CPU: begin
                sel_valid_s = 1'b1;
                sel_we_s    = cpu_we;
                sel_addr_s  = cpu_addr;
                sel_wdata_s = cpu_wdata;
            end
            REQ_DMA: begin
                sel_valid_s = 1'b1;
                sel_we_s    = dma_we;
                sel_addr_s  = dma_addr;
                sel_wdata_s = dma_wdata;
            end
            default: begin
                sel_valid_s = 1'b0;
                sel_we_s    = 1'b0;
                sel_addr_s  = 16'h0000;
                sel_wdata_s = 16'h0000;
            end
        endcase
    end

    assign sel_in_range_s = addr_in_range(sel_addr_s);

    // Out-of-range reads still get a tag so the requester sees its rvalid
    always_comb begin
        new_tag_s       = '0;
        new_tag_s.valid = sel_valid_s && !sel_we_s;
        new_tag_s.oor   = !sel_in_range_s;
        new_tag_s.owner = grant_s;
    end

    // CPU wait counter: counts unacked request cycles, saturating
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (!cpu_req || cpu_ack) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (wait_cnt_r != {WAIT_W{1'b1}}) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end
    end

    // Round-robin pointer hands preference to the other side after each CPU/DMA grant
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            rr_cpu_r <= 1'b1;
        end else if (grant_s == REQ_CPU) begin
            rr_cpu_r <= 1'b0;
        end else if (grant_s == REQ_DMA) begin
            rr_cpu_r <= 1'b1;
        end
    end

    // VRAM command registers; address/data hold when nothing is issued
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            vram_re    <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= 16'h0000;
            vram_wdata <= 16'h0000;
        end else begin
            vram_re <= sel_valid_s && !sel_we_s && sel_in_range_s;
            vram_we <= sel_valid_s &&  sel_we_s && sel_in_range_s;
            if (sel_valid_s && sel_in_range_s) begin
                vram_addr <= sel_addr_s;
                if (sel_we_s) begin
                    vram_wdata <= sel_wdata_s;
                end
            end
        end
    end

    // Read tag pipeline aligned with the VRAM read latency
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            for (int i = 0; i < VRAM_RD_LAT; i++) begin
                tag_pipe_r[i] <= '0;
            end
        end else begin
            tag_pipe_r[0] <= new_tag_s;
            for (int i = 1; i < VRAM_RD_LAT; i++) begin
                tag_pipe_r[i] <= tag_pipe_r[i-1];
            end
        end
    end

    assign ret_tag_s  = tag_pipe_r[VRAM_RD_LAT-1];
    assign bg_rvalid  = ret_tag_s.valid && (ret_tag_s.owner == REQ_BG);
    assign cpu_rvalid = ret_tag_s.valid && (ret_tag_s.owner == REQ_CPU);
    assign dma_rvalid = ret_tag_s.valid && (ret_tag_s.owner == REQ_DMA);
    assign rdata      = (ret_tag_s.valid && !ret_tag_s.oor) ? vram_rdata : 16'h0000;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a VRAM model and a read-return scoreboard.
module tb_vram_arbiter;

    logic        clock = 1'b0;
    logic        reset_N = 1'b0;
    logic        bg_req = 1'b0;
    logic [15:0] bg_addr = 16'h0000;
    logic        bg_ack, bg_rvalid;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000, cpu_wdata = 16'h0000;
    logic        cpu_ack, cpu_rvalid;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = 16'h0000, dma_wdata = 16'h0000;
    logic        dma_ack, dma_rvalid;
    logic [15:0] rdata, vram_addr, vram_wdata;
    logic        vram_re, vram_we;
    logic [15:0] vram_rdata = 16'h0000;

    typedef struct {
        int          owner;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    vram_arbiter dut (
        .clock(clock), .reset_N(reset_N),
        .bg_req(bg_req), .bg_addr(bg_addr), .bg_ack(bg_ack), .bg_rvalid(bg_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rvalid(dma_rvalid),
        .rdata(rdata), .vram_addr(vram_addr), .vram_re(vram_re), .vram_we(vram_we),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // VRAM model: read data appears the cycle after vram_re
    always @(posedge clock) begin
        if (vram_we) mem[vram_addr[14:0]] <= vram_wdata;
        if (vram_re) vram_rdata <= mem[vram_addr[14:0]];
    end

    function automatic logic [15:0] pat(input int i);
        return 16'(i) ^ 16'hA5A5;
    endfunction

    function automatic logic [15:0] exp_data(input logic [15:0] a);
        return a[15] ? 16'h0000 : ref_mem[a[14:0]];
    endfunction

    // Record accepted requests just before the active edge
    always @(negedge clock) begin
        #4;
        if (reset_N) begin
            if (bg_req && bg_ack) exp_q.push_back('{1, exp_data(bg_addr), cyc + 2});
            if (cpu_req && cpu_ack) begin
                if (cpu_we) begin
                    if (!cpu_addr[15]) ref_mem[cpu_addr[14:0]] = cpu_wdata;
                end else begin
                    exp_q.push_back('{2, exp_data(cpu_addr), cyc + 2});
                end
            end
            if (dma_req && dma_ack) begin
                if (dma_we) begin
                    if (!dma_addr[15]) ref_mem[dma_addr[14:0]] = dma_wdata;
                end else begin
                    exp_q.push_back('{3, exp_data(dma_addr), cyc + 2});
                end
            end
        end
    end

    // Scoreboard: every rvalid must match the oldest expected read
    always @(negedge clock) begin
        int   got;
        int   n;
        exp_t e;
        got = 0;
        n   = 0;
        if (bg_rvalid)  begin got = 1; n++; end
        if (cpu_rvalid) begin got = 2; n++; end
        if (dma_rvalid) begin got = 3; n++; end
        if (vram_re || vram_we) begin
            checks++;
            if (vram_re && vram_we) begin
                failures++;
                $display("FAIL re_we_exclusive cyc=%0d re=%b we=%b required not both", cyc, vram_re, vram_we);
            end
        end
        if (n > 0) begin
            checks++;
            if (n > 1) begin
                failures++;
                $display("FAIL rvalid_onehot cyc=%0d count=%0d required 1", cyc, n);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected cyc=%0d owner=%0d required none", cyc, got);
            end else begin
                e = exp_q.pop_front();
                if (got != e.owner || rdata !== e.data || cyc != e.due) begin
                    failures++;
                    $display("FAIL read_return cyc=%0d owner=%0d rdata=%h required cyc=%0d owner=%0d rdata=%h",
                             cyc, got, rdata, e.due, e.owner, e.data);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            checks++;
            failures++;
            e = exp_q.pop_front();
            $display("FAIL rvalid_missing cyc=%0d owner=%0d required rvalid at cyc=%0d", cyc, e.owner, e.due);
        end
    end

    task automatic idle();
        bg_req  = 1'b0;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        dma_req = 1'b0;
        dma_we  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        idle();
        reset_N = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_N = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bg_ack, cpu_ack, dma_ack, bg_rvalid, cpu_rvalid, dma_rvalid, vram_re, vram_we,
             vram_addr, vram_wdata, rdata} !== 56'h0) begin
            failures++;
            $display("FAIL reset_outputs acks=%b%b%b rv=%b%b%b re=%b we=%b addr=%h wd=%h rd=%h required all 0",
                     bg_ack, cpu_ack, dma_ack, bg_rvalid, cpu_rvalid, dma_rvalid, vram_re, vram_we,
                     vram_addr, vram_wdata, rdata);
        end
        @(negedge clock);
        reset_N = 1'b1;
    endtask

    task automatic test_bg_read();
        @(negedge clock);
        bg_req = 1'b1; bg_addr = 16'h0100; #1;
        checks++;
        if ({bg_ack, cpu_ack, dma_ack} !== 3'b100) begin
            failures++;
            $display("FAIL bg_ack acks=%b required 100", {bg_ack, cpu_ack, dma_ack});
        end
        @(negedge clock);
        bg_req = 1'b0; #1;
        checks++;
        if (vram_re !== 1'b1 || vram_we !== 1'b0 || vram_addr !== 16'h0100) begin
            failures++;
            $display("FAIL bg_cmd re=%b we=%b addr=%h required re=1 we=0 addr=0100", vram_re, vram_we, vram_addr);
        end
        @(negedge clock); #1;
        checks++;
        if (bg_rvalid !== 1'b1 || rdata !== 16'hA4A5) begin
            failures++;
            $display("FAIL bg_rvalid rv=%b rdata=%h required rv=1 rdata=a4a5", bg_rvalid, rdata);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h1234; #1;
        checks++;
        if (cpu_ack !== 1'b1) begin
            failures++;
            $display("FAIL cpu_wr_ack ack=%b required 1", cpu_ack);
        end
        @(negedge clock);
        cpu_we = 1'b0; #1;
        checks++;
        if (cpu_ack !== 1'b1 || vram_we !== 1'b1 || vram_re !== 1'b0 || vram_addr !== 16'h0040 || vram_wdata !== 16'h1234) begin
            failures++;
            $display("FAIL cpu_wr_cmd ack=%b we=%b re=%b addr=%h wd=%h required ack=1 we=1 re=0 addr=0040 wd=1234",
                     cpu_ack, vram_we, vram_re, vram_addr, vram_wdata);
        end
        @(negedge clock);
        idle(); #1;
        checks++;
        if (vram_re !== 1'b1 || vram_we !== 1'b0 || vram_addr !== 16'h0040) begin
            failures++;
            $display("FAIL cpu_rd_cmd re=%b we=%b addr=%h required re=1 we=0 addr=0040", vram_re, vram_we, vram_addr);
        end
        @(negedge clock); #1;
        checks++;
        if (cpu_rvalid !== 1'b1 || rdata !== 16'h1234) begin
            failures++;
            $display("FAIL cpu_rd_data rv=%b rdata=%h required rv=1 rdata=1234", cpu_rvalid, rdata);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0020; #1;
            checks++;
            if ({bg_ack, cpu_ack, dma_ack} !== ((i % 2 == 0) ? 3'b010 : 3'b001)) begin
                failures++;
                $display("FAIL rr_ack step=%0d acks=%b required %b", i, {bg_ack, cpu_ack, dma_ack},
                         ((i % 2 == 0) ? 3'b010 : 3'b001));
            end
        end
        @(negedge clock);
        idle();
        repeat (3) @(negedge clock);
    endtask

    task automatic test_cpu_starvation();
        for (int i = 1; i <= 18; i++) begin
            @(negedge clock);
            bg_req = 1'b1; bg_addr = 16'h0200;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030; #1;
            checks++;
            if ({bg_ack, cpu_ack, dma_ack} !== ((i == 9 || i == 18) ? 3'b010 : 3'b100)) begin
                failures++;
                $display("FAIL starve_ack cycle=%0d acks=%b required %b", i, {bg_ack, cpu_ack, dma_ack},
                         ((i == 9 || i == 18) ? 3'b010 : 3'b100));
            end
        end
        @(negedge clock);
        idle();
        repeat (3) @(negedge clock);
    endtask

    task automatic test_out_of_range();
        @(negedge clock);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h8005; dma_wdata = 16'hBEEF; #1;
        checks++;
        if (dma_ack !== 1'b1) begin
            failures++;
            $display("FAIL oor_wr_ack ack=%b required 1", dma_ack);
        end
        @(negedge clock);
        dma_we = 1'b0; #1;
        checks++;
        if (dma_ack !== 1'b1 || vram_we !== 1'b0 || vram_re !== 1'b0) begin
            failures++;
            $display("FAIL oor_wr_drop ack=%b we=%b re=%b required ack=1 we=0 re=0", dma_ack, vram_we, vram_re);
        end
        @(negedge clock);
        dma_addr = 16'h0005; #1;
        checks++;
        if (vram_re !== 1'b0 || vram_we !== 1'b0) begin
            failures++;
            $display("FAIL oor_rd_drop re=%b we=%b required re=0 we=0", vram_re, vram_we);
        end
        @(negedge clock);
        idle(); #1;
        checks++;
        if (dma_rvalid !== 1'b1 || rdata !== 16'h0000 || vram_re !== 1'b1) begin
            failures++;
            $display("FAIL oor_rd_return rv=%b rdata=%h re=%b required rv=1 rdata=0000 re=1", dma_rvalid, rdata, vram_re);
        end
        @(negedge clock); #1;
        checks++;
        if (dma_rvalid !== 1'b1 || rdata !== 16'hA5A0) begin
            failures++;
            $display("FAIL alias_untouched rv=%b rdata=%h required rv=1 rdata=a5a0", dma_rvalid, rdata);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040; #1;
        checks++;
        if (cpu_ack !== 1'b1) begin
            failures++;
            $display("FAIL mid_rd_ack ack=%b required 1", cpu_ack);
        end
        @(negedge clock);
        idle();
        reset_N = 1'b0;
        exp_q.delete(); #1;
        checks++;
        if ({bg_ack, cpu_ack, dma_ack, bg_rvalid, cpu_rvalid, dma_rvalid, vram_re, vram_we,
             vram_addr, vram_wdata, rdata} !== 56'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs re=%b we=%b addr=%h wd=%h rd=%h required all 0",
                     vram_re, vram_we, vram_addr, vram_wdata, rdata);
        end
        @(negedge clock);
        reset_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); #1;
            checks++;
            if (cpu_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL flushed_read step=%0d rv=%b required 0", i, cpu_rvalid);
            end
        end
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        @(negedge clock);
        idle();
        repeat (4) @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = pat(i);
            ref_mem[i] = pat(i);
        end
        test_reset();
        test_bg_read();
        test_back_to_back();
        test_round_robin();
        test_cpu_starvation();
        test_out_of_range();
        test_reset_mid_read();
        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
